// File: rtl/generador_de_tono.sv
// generador_de_tono: square-wave buzzer driver; half-period computed by a sequential restoring divider
module generador_de_tono #(
   parameter int FREC_CLK   = 12000000,
   parameter int ANCHO_CONT = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] frecuencia,
   input  logic       habilitar,
   output logic       parlante,
   output logic       ocupado
);
   localparam int ANCHO_BIT = $clog2(ANCHO_CONT);
   localparam logic [ANCHO_CONT-1:0] DIVIDENDO = ANCHO_CONT'(FREC_CLK / 2);
   typedef enum logic [1:0] {SILENCIO, CALCULO, SONANDO} estado_t;
   estado_t                r_estado;
   logic [9:0]             r_frec_actual;
   logic [ANCHO_CONT-1:0]  r_medio_periodo;
   logic [ANCHO_CONT-1:0]  r_contador;
   logic [ANCHO_CONT-1:0]  r_cociente;
   logic [ANCHO_CONT:0]    r_resto;
   logic [ANCHO_BIT-1:0]   r_bit;
   logic                   r_parlante;
   logic                   r_ocupado;
   logic [ANCHO_CONT:0]    w_divisor;
   logic [ANCHO_CONT:0]    w_resto_desp;
   logic                   w_cabe;
   logic [ANCHO_CONT-1:0]  w_cociente_sig;
   logic                   w_iniciar;
   logic                   w_fin_medio;
   assign w_divisor      = (ANCHO_CONT+1)'(r_frec_actual);
   assign w_resto_desp   = {r_resto[ANCHO_CONT-1:0], DIVIDENDO[r_bit]};
   assign w_cabe         = w_resto_desp >= w_divisor;
   assign w_cociente_sig = {r_cociente[ANCHO_CONT-2:0], w_cabe};
   assign w_fin_medio    = r_contador == r_medio_periodo - ANCHO_CONT'(1);
   // a new division starts from silence on any nonzero pitch, or from a playing tone on a pitch change
   assign w_iniciar = (frecuencia != 10'd0) &&
                      ((r_estado == SILENCIO) || (r_estado == SONANDO && frecuencia != r_frec_actual));
   always_ff @(posedge clk) begin
      if (reset) begin
         r_estado        <= SILENCIO;
         r_frec_actual   <= '0;
         r_medio_periodo <= '0;
         r_contador      <= '0;
         r_cociente      <= '0;
         r_resto         <= '0;
         r_bit           <= '0;
         r_parlante      <= 1'b0;
         r_ocupado       <= 1'b0;
      end else if (w_iniciar) begin
         r_estado      <= CALCULO;
         r_frec_actual <= frecuencia;
         r_resto       <= '0;
         r_cociente    <= '0;
         r_bit         <= ANCHO_BIT'(ANCHO_CONT - 1);
         r_contador    <= '0;
         r_parlante    <= 1'b0;
         r_ocupado     <= 1'b1;
      end else begin
         case (r_estado)
            SILENCIO: begin
               r_contador <= '0;
               r_parlante <= 1'b0;
            end
            CALCULO: begin
               r_resto    <= w_cabe ? w_resto_desp - w_divisor : w_resto_desp;
               r_cociente <= w_cociente_sig;
               r_bit      <= r_bit - ANCHO_BIT'(1);
               if (r_bit == '0) begin
                  r_medio_periodo <= (w_cociente_sig == '0) ? ANCHO_CONT'(1) : w_cociente_sig;
                  r_ocupado       <= 1'b0;
                  r_estado        <= SONANDO;
               end
            end
            SONANDO: begin
               if (frecuencia == 10'd0) begin
                  r_estado      <= SILENCIO;
                  r_frec_actual <= '0;
                  r_contador    <= '0;
                  r_parlante    <= 1'b0;
               end else if (habilitar) begin
                  r_contador <= w_fin_medio ? '0 : r_contador + ANCHO_CONT'(1);
                  r_parlante <= w_fin_medio ? ~r_parlante : r_parlante;
               end else begin
                  r_contador <= '0;
                  r_parlante <= 1'b0;
               end
            end
            default: r_estado <= SILENCIO;
         endcase
      end
   end
   assign parlante = r_parlante;
   assign ocupado  = r_ocupado;
endmodule

// File: tb/tb_generador_de_tono.sv
// tb_generador_de_tono: scoreboard bench; stimulus queues expected half-periods, a monitor measures the buzzer
module tb_generador_de_tono;
   localparam int FCLK  = 1200000;
   localparam int FCLK2 = 2000;
   localparam int BUSY  = 24;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] frecuencia = '0;
   logic [9:0] frec2 = '0;
   logic       habilitar = 1'b1;
   logic       parlante, ocupado, parl2, ocu2;
   int         errors = 0;
   int         checks = 0;
   int         exp_q[$];
   generador_de_tono #(.FREC_CLK(FCLK), .ANCHO_CONT(24)) dut (
      .clk(clk), .reset(reset), .frecuencia(frecuencia), .habilitar(habilitar),
      .parlante(parlante), .ocupado(ocupado)
   );
   generador_de_tono #(.FREC_CLK(FCLK2), .ANCHO_CONT(24)) dut_clamp (
      .clk(clk), .reset(reset), .frecuencia(frec2), .habilitar(habilitar),
      .parlante(parl2), .ocupado(ocu2)
   );
   always #5 clk = ~clk;
   function automatic int half(input int fclk, input int f);
      int q;
      q = (fclk / 2) / f;
      return (q < 1) ? 1 : q;
   endfunction
   task automatic check(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic wait_ocu(input logic v, input int lim, input string nm);
      int n = 0;
      while (ocupado !== v && n < lim) begin
         tick(1);
         n++;
      end
      check(nm, int'(ocupado), int'(v));
   endtask
   task automatic wait_par(input logic v, input int lim, input string nm);
      int n = 0;
      while (parlante !== v && n < lim) begin
         tick(1);
         n++;
      end
      check(nm, int'(parlante), int'(v));
   endtask
   task automatic tone(input int f);
      frecuencia = 10'(f);
      exp_q.push_back(half(FCLK, f));
      tick(BUSY + 10 + 3 * half(FCLK, f));
   endtask
   task automatic measure_clamp(input int hm, input string nm);
      int  n;
      logic p;
      n = 0;
      p = parl2;
      while (parl2 === p && n < 10) begin
         tick(1);
         n++;
      end
      for (int k = 0; k < 4; k++) begin
         p = parl2;
         n = 0;
         do begin
            tick(1);
            n++;
         end while (parl2 === p && n < hm + 3);
         check(nm, n, hm);
      end
   endtask
   // monitor: every completed division pops one expected half-period and measures one full period
   initial begin : monitor
      string nombres[3] = '{"rise_delay", "high_width", "low_width"};
      int    busy_cnt = 0;
      int    h = 0;
      int    cnt = 0;
      int    fase = 0;
      bit    busy_par = 0;
      bit    armed = 0;
      logic  prev_ocu = 1'b0;
      logic  prev_par = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (reset) begin
            armed = 0;
            busy_cnt = 0;
            busy_par = 0;
         end else if (ocupado) begin
            armed = 0;
            busy_cnt++;
            if (parlante) busy_par = 1;
         end else if (prev_ocu) begin
            check("busy_len", busy_cnt, BUSY);
            check("silent_during_busy", int'(busy_par), 0);
            busy_cnt = 0;
            busy_par = 0;
            check("division_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               h = exp_q.pop_front();
               armed = 1;
               cnt = 0;
               fase = 0;
            end
         end else if (armed) begin
            if (!habilitar) armed = 0;
            else begin
               cnt++;
               if (parlante !== prev_par) begin
                  check(nombres[fase], cnt, h);
                  cnt = 0;
                  fase++;
                  if (fase == 3) armed = 0;
               end else if (cnt > h + 2) begin
                  check({nombres[fase], "_timeout"}, cnt, h);
                  armed = 0;
               end
            end
         end
         prev_ocu = ocupado;
         prev_par = parlante;
      end
   end
   initial begin : watchdog
      #(1_000_000 * 10);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1);
   end
   initial begin : stimulus
      int   n;
      int   prev;
      int   f;
      bit   bad;
      tick(3);
      reset = 1'b0;
      check("reset_ocupado", int'(ocupado), 0);
      check("reset_parlante", int'(parlante), 0);
      bad = 0;
      repeat (1000) begin
         tick(1);
         if (parlante !== 1'b0 || ocupado !== 1'b0) bad = 1;
      end
      check("idle_silence", int'(bad), 0);
      tone(440);
      tone(262);
      tone(1000);
      tone(1023);
      // pitch change in the middle of a division
      frecuencia = 10'd440;
      exp_q.push_back(half(FCLK, 440));
      exp_q.push_back(half(FCLK, 523));
      wait_ocu(1'b1, 5, "t4_start");
      tick(9);
      frecuencia = 10'd523;
      wait_ocu(1'b0, 30, "t4_first_done");
      check("t4_gap_parlante", int'(parlante), 0);
      tick(1);
      check("t4_recalc", int'(ocupado), 1);
      tick(BUSY + 10 + 3 * half(FCLK, 523));
      // quotient below one is clamped
      frec2 = 10'd1023;
      tick(BUSY + 6);
      measure_clamp(half(FCLK2, 1023), "clamp_run_1023");
      frec2 = 10'd400;
      tick(BUSY + 6);
      measure_clamp(half(FCLK2, 400), "clamp_run_400");
      frec2 = 10'd0;
      // habilitar gating and rest
      tone(1000);
      wait_par(1'b1, 2 * half(FCLK, 1000) + 5, "t5_high");
      habilitar = 1'b0;
      tick(1);
      check("t5_mute_now", int'(parlante), 0);
      bad = 0;
      repeat (5000) begin
         tick(1);
         if (parlante !== 1'b0 || ocupado !== 1'b0) bad = 1;
      end
      check("t5_muted", int'(bad), 0);
      habilitar = 1'b1;
      n = 0;
      while (parlante !== 1'b1 && n < half(FCLK, 1000) + 100) begin
         tick(1);
         n++;
      end
      check("t5_restart_rise", n, half(FCLK, 1000));
      frecuencia = 10'd0;
      tick(1);
      check("t5_rest_now", int'(parlante), 0);
      bad = 0;
      repeat (100) begin
         tick(1);
         if (parlante !== 1'b0 || ocupado !== 1'b0) bad = 1;
      end
      check("t5_rest_hold", int'(bad), 0);
      // reset in the middle of a division
      frecuencia = 10'd440;
      wait_ocu(1'b1, 5, "t6_start");
      tick(11);
      reset = 1'b1;
      tick(1);
      check("t6_rst_calc_ocupado", int'(ocupado), 0);
      check("t6_rst_calc_parlante", int'(parlante), 0);
      exp_q.push_back(half(FCLK, 440));
      reset = 1'b0;
      wait_ocu(1'b1, 5, "t6_rerun");
      tick(BUSY + 10 + 3 * half(FCLK, 440));
      // reset while the tone is high
      wait_par(1'b1, 2 * half(FCLK, 440) + 5, "t6_high");
      reset = 1'b1;
      tick(1);
      check("t6_rst_play_ocupado", int'(ocupado), 0);
      check("t6_rst_play_parlante", int'(parlante), 0);
      exp_q.push_back(half(FCLK, 440));
      reset = 1'b0;
      wait_ocu(1'b1, 5, "t6_rerun2");
      tick(BUSY + 10 + 3 * half(FCLK, 440));
      prev = 440;
      repeat (5) begin
         do f = int'($urandom_range(400, 1023)); while (f == prev);
         tone(f);
         prev = f;
      end
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
